// File: rtl/mempool_dma_split_midend.sv
// Splits one 1D DMA transfer into ChunkBytes-aligned destination chunks for a single
// iDMA backend, tracks chunks in flight and pulses one completion per original transfer.
module mempool_dma_split_midend #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned ChunkBytes     = 1024,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  req_valid_i,
  output logic                                  req_ready_o,
  input  logic [AddrWidth-1:0]                  req_src_i,
  input  logic [AddrWidth-1:0]                  req_dst_i,
  input  logic [AddrWidth-1:0]                  req_num_bytes_i,
  output logic                                  be_valid_o,
  input  logic                                  be_ready_i,
  output logic [AddrWidth-1:0]                  be_src_o,
  output logic [AddrWidth-1:0]                  be_dst_o,
  output logic [AddrWidth-1:0]                  be_num_bytes_o,
  input  logic                                  be_trans_complete_i,
  output logic                                  trans_complete_o,
  output logic                                  idle_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [AddrWidth-1:0] ChunkSize = AddrWidth'(ChunkBytes);
  localparam logic [AddrWidth-1:0] ChunkMask = AddrWidth'(ChunkBytes - 1);
  localparam logic [CntW-1:0]      MaxOut    = CntW'(MaxOutstanding);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SPLIT,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e               r_state;
  logic [AddrWidth-1:0] r_src;
  logic [AddrWidth-1:0] r_dst;
  logic [AddrWidth-1:0] r_rem;
  logic [CntW-1:0]      r_out;

  logic [AddrWidth-1:0] w_room;
  logic [AddrWidth-1:0] w_len;
  logic                 w_be_hs;
  logic                 w_dec;
  logic [CntW-1:0]      w_out_next;

  assign be_valid_o       = (r_state == S_SPLIT) && (r_out < MaxOut);
  assign req_ready_o      = (r_state == S_IDLE);
  assign trans_complete_o = (r_state == S_DONE);
  assign idle_o           = (r_state == S_IDLE) && (r_out == '0);
  assign be_src_o         = r_src;
  assign be_dst_o         = r_dst;
  assign be_num_bytes_o   = w_len;
  assign outstanding_o    = r_out;

  always_comb begin
    w_room  = ChunkSize - (r_dst & ChunkMask);
    w_len   = (r_rem < w_room) ? r_rem : w_room;
    w_be_hs = be_valid_o && be_ready_i;
    // a completion with nothing in flight is spurious and must not underflow
    w_dec   = be_trans_complete_i && (r_out != '0);
    case ({w_be_hs, w_dec})
      2'b10:   w_out_next = r_out + CntW'(1);
      2'b01:   w_out_next = r_out - CntW'(1);
      default: w_out_next = r_out;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_rem   <= '0;
      r_out   <= '0;
    end else begin
      r_out <= w_out_next;
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            if (req_num_bytes_i != '0) begin
              r_src   <= req_src_i;
              r_dst   <= req_dst_i;
              r_rem   <= req_num_bytes_i;
              r_state <= S_SPLIT;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_SPLIT: begin
          if (w_be_hs) begin
            r_src <= r_src + w_len;
            r_dst <= r_dst + w_len;
            r_rem <= r_rem - w_len;
            if (w_len == r_rem) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_out_next == '0) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
